// File: rtl/obi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obi_arb_pkg
//  Description : Shared types and helpers for the OBI round-robin arbiter.
//                Contents:
//                  - mgr_idx_t   : manager index, sized for up to 8 managers
//                  - arb_state_e : A-channel arbitration state (IDLE/WAIT_GNT)
//                  - rr_pick_t   : result of a round-robin pick
//                  - rr_pick()   : first requester at or after a pointer,
//                                  wrapping modulo the manager count
//  Revision    : 1.0 - initial release
// ============================================================================
package obi_arb_pkg;

    localparam int NUM_MGR_MAX = 8;
    localparam int MGR_IDX_W   = $clog2(NUM_MGR_MAX);

    typedef logic [MGR_IDX_W-1:0] mgr_idx_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic     valid;
        mgr_idx_t idx;
    } rr_pick_t;

    // Scans num candidates starting at ptr. The requests are zero-padded to
    // NUM_MGR_MAX bits so a single function serves every NUM_MGR setting.
    function automatic rr_pick_t rr_pick(
        input logic [NUM_MGR_MAX-1:0] req,
        input mgr_idx_t               ptr,
        input int                     num
    );
        rr_pick_t res;
        int       j;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < NUM_MGR_MAX; i++) begin
            j = int'(ptr) + i;
            if (j >= num) begin
                j = j - num;
            end
            if ((i < num) && !res.valid && req[j[MGR_IDX_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = j[MGR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage : obi_arb_pkg
`default_nettype wire

// File: rtl/obi_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : obi_id_fifo
//  Description : In-order FIFO of granted manager indices. Each entry is one
//                accepted A-channel transaction that still awaits its
//                R-channel response.
//  Ports       : clk_i, reset_ni     - clock, async active-low reset
//                push, push_idx      - enqueue a manager index (ignored if full)
//                pop                 - dequeue the head (ignored if empty)
//                full, empty         - occupancy flags
//                head                - index at the front of the queue
//  Revision    : 1.0 - initial release
// ============================================================================
module obi_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     reset_ni,
    input  logic     push,
    input  mgr_idx_t push_idx,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output mgr_idx_t head
);

    // A depth of one still needs a 1-bit pointer to keep the array indexable.
    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    mgr_idx_t             r_mem [DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    assign full   = (r_count == C_CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        if (p == C_PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + C_PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is qualified by the pointers and needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_idx;
        end
    end

endmodule : obi_id_fifo
`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : obi_rr_arbiter
//  Description : Round-robin arbiter sharing one OBI subordinate between
//                NUM_MGR managers. Both channels are combinational; an ID
//                FIFO records the granting order so responses return to the
//                manager that issued them.
//  Ports       : clk_i, reset_ni             - clock, async active-low reset
//                m_req_i/m_gnt_o             - per-manager A handshake
//                m_addr_i/m_we_i/m_be_i/
//                m_wdata_i                   - packed manager A payloads
//                m_rvalid_o/m_rready_i       - per-manager R handshake
//                m_rdata_o/m_err_o           - R payload, broadcast
//                s_req_o/s_gnt_i, s_addr_o,
//                s_we_o/s_be_o/s_wdata_o     - subordinate A-channel
//                s_rvalid_i/s_rready_o,
//                s_rdata_i/s_err_i           - subordinate R-channel
//  Revision    : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_MGR         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [NUM_MGR-1:0]              m_req_i,
    output logic [NUM_MGR-1:0]              m_gnt_o,
    input  logic [NUM_MGR*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MGR-1:0]              m_we_i,
    input  logic [NUM_MGR*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MGR*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MGR-1:0]              m_rvalid_o,
    input  logic [NUM_MGR-1:0]              m_rready_i,
    output logic [DATA_WIDTH-1:0]           m_rdata_o,
    output logic                            m_err_o,
    output logic                            s_req_o,
    output logic [ADDR_WIDTH-1:0]           s_addr_o,
    output logic                            s_we_o,
    output logic [DATA_WIDTH/8-1:0]         s_be_o,
    output logic [DATA_WIDTH-1:0]           s_wdata_o,
    input  logic                            s_gnt_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           s_rdata_i,
    input  logic                            s_err_i,
    output logic                            s_rready_o
);

    localparam int C_BE_W = DATA_WIDTH / 8;
    localparam int C_RR_W = $clog2(NUM_MGR);

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    mgr_idx_t               r_lock_idx;
    logic [C_RR_W-1:0]      r_rr;
    logic [C_RR_W-1:0]      w_rr_next;
    logic [NUM_MGR_MAX-1:0] w_req_pad;
    rr_pick_t               w_pick;
    mgr_idx_t               w_winner;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    mgr_idx_t               w_head;

    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_MGR-1:0] = m_req_i;
    end

    assign w_pick = rr_pick(w_req_pad, mgr_idx_t'(r_rr), NUM_MGR);

    // ------------------------------------------------------------------
    // Arbitration state. WAIT_GNT is the lock: a request that was issued
    // but not yet granted keeps its winner until the subordinate takes it.
    // Full is only consulted when a new request would be issued; a lock
    // already owns a reserved FIFO slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_winner     = w_pick.idx;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue = w_pick.valid & ~w_full;
                if (w_issue && !s_gnt_i && reset_ni) begin
                    w_state_next = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                w_winner = r_lock_idx;
                w_issue  = 1'b1;
                if (s_gnt_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Nothing leaves the block while reset is asserted.
        w_issue = w_issue & reset_ni;
    end

    assign w_push = w_issue & s_gnt_i;

    always_comb begin
        if (w_winner == mgr_idx_t'(NUM_MGR - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = C_RR_W'(w_winner + mgr_idx_t'(1));
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rr       <= '0;
            r_lock_idx <= '0;
        end else begin
            if (w_push) begin
                r_rr <= w_rr_next;
            end
            if ((r_state == IDLE) && (w_state_next == WAIT_GNT)) begin
                r_lock_idx <= w_pick.idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // A-channel: mux the winner's slice, zero when nothing is issued.
    // ------------------------------------------------------------------
    always_comb begin
        s_req_o   = w_issue;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        for (int k = 0; k < NUM_MGR; k++) begin
            if (w_issue && (w_winner == mgr_idx_t'(k))) begin
                s_addr_o   = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o     = m_we_i[k];
                s_be_o     = m_be_i[k*C_BE_W +: C_BE_W];
                s_wdata_o  = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                m_gnt_o[k] = s_gnt_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // R-channel: the FIFO head names the destination. With nothing
    // outstanding any response is stray and is absorbed silently; the
    // reset_ni term keeps s_rready_o low while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        m_rvalid_o = '0;
        s_rready_o = reset_ni;
        if (!w_empty) begin
            s_rready_o = 1'b0;
            for (int k = 0; k < NUM_MGR; k++) begin
                if (w_head == mgr_idx_t'(k)) begin
                    m_rvalid_o[k] = s_rvalid_i;
                    s_rready_o    = m_rready_i[k];
                end
            end
        end
    end

    assign w_pop     = s_rvalid_i & s_rready_o & ~w_empty;
    assign m_rdata_o = s_rdata_i;
    assign m_err_o   = s_err_i;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (w_push),
        .push_idx (w_winner),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head)
    );

endmodule : obi_rr_arbiter
`default_nettype wire
